// File: rtl/zz_defs.sv
// Shared definitions for the zig-zag bit-plane accumulator: default precision
// width, position-register width rule and FSM state encoding.
package zz_defs;

  localparam int ZZ_BPREC = 4;

  // Walk position registers need one bit more than pw/pd so diagonal sums fit.
  function automatic int zz_sump_w(input int bprec);
    return bprec + 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } zz_state_e;

endpackage

// File: rtl/zz_walk_step.sv
// Combinational next-position step of the zig-zag (offw, offd) bit-plane walk.
// Shared between the accumulator and the address generator.
module zz_walk_step
  import zz_defs::*;
#(
  parameter int W = zz_sump_w(ZZ_BPREC)
) (
  input  logic [W-1:0] i_iw,
  input  logic [W-1:0] i_id,
  input  logic [W-1:0] i_pw,
  input  logic [W-1:0] i_pd,
  output logic [W-1:0] o_iw_n,
  output logic [W-1:0] o_id_n,
  output logic         o_sh,
  output logic         o_wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] w_iw;
  logic [W-1:0] w_id;

  always_comb begin
    o_sh   = (i_iw == '0) | (i_id == i_pd - ONE);
    o_wrap = 1'b0;
    w_id   = i_id + ONE;
    w_iw   = i_iw - ONE;
    // End of a diagonal: jump to the start of the next one, clamped into the grid.
    if (o_sh) begin
      w_iw = w_iw + w_id + ONE;
      w_id = '0;
      if (w_iw >= i_pw + i_pd - ONE) begin
        w_iw   = '0;
        w_id   = '0;
        o_wrap = 1'b1;
      end else if (w_iw >= i_pw) begin
        w_id = w_iw - i_pw + ONE;
        w_iw = w_iw - w_id;
      end else if (w_id >= i_pd) begin
        w_iw = w_id - i_pd + ONE;
        w_id = w_id - w_iw;
      end
    end
    o_iw_n = w_iw;
    o_id_n = w_id;
  end

endmodule

// File: rtl/zigzag_acc.sv
// Zig-zag bit-plane product accumulator: sign-corrects and shift-accumulates popcounts.
// Optional shift cross-check against the producer's in_sh: define ZIGZAG_ACC_SH_CHECK_EN.
module zigzag_acc
  import zz_defs::*;
#(
  parameter int BPREC = ZZ_BPREC,
  parameter int BPP   = 8,
  parameter int BACC  = 32
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [BPREC-1:0]       pw,
  input  logic [BPREC-1:0]       pd,
  input  logic                   sw,
  input  logic                   sd,
  input  logic                   in_valid,
  input  logic [BPP-1:0]         in_pp,
  input  logic                   in_sh,
  output logic                   out_valid,
  output logic signed [BACC-1:0] out_acc,
  output logic                   busy,
  output logic                   err
);

  localparam int W = zz_sump_w(BPREC);
  localparam logic [W-1:0] ONE = W'(1);

  function automatic logic [W-1:0] f_eff_prec(input logic [BPREC-1:0] p);
    return (p == '0) ? ONE : W'(p);
  endfunction

  function automatic logic signed [BACC-1:0] f_term(input logic [BPP-1:0] pp, input logic neg);
    logic signed [BACC-1:0] v;
    v = $signed(BACC'(pp));
    return neg ? -v : v;
  endfunction

  zz_state_e              r_state;
  logic [W-1:0]           r_pw, r_pd, r_iw, r_id;
  logic                   r_sw, r_sd, r_newdiag, r_busy, r_out_valid;
  logic signed [BACC-1:0] r_acc, r_out_acc;

  logic                   w_first, w_sw, w_sd, w_sh, w_wrap, w_neg;
  logic [W-1:0]           w_pw, w_pd, w_iw_n, w_id_n;
  logic signed [BACC-1:0] w_term, w_acc_n;

  // Precision and signedness come live from the ports only on the first term.
  assign w_first = (r_state == ST_IDLE);
  assign w_pw    = w_first ? f_eff_prec(pw) : r_pw;
  assign w_pd    = w_first ? f_eff_prec(pd) : r_pd;
  assign w_sw    = w_first ? sw : r_sw;
  assign w_sd    = w_first ? sd : r_sd;

  zz_walk_step #(.W(W)) u_step (
    .i_iw   (r_iw),
    .i_id   (r_id),
    .i_pw   (w_pw),
    .i_pd   (w_pd),
    .o_iw_n (w_iw_n),
    .o_id_n (w_id_n),
    .o_sh   (w_sh),
    .o_wrap (w_wrap)
  );

  assign w_neg  = (w_sw & (r_iw == '0) & (w_pw > ONE)) ^ (w_sd & (r_id == '0) & (w_pd > ONE));
  assign w_term = f_term(in_pp, w_neg);

  always_comb begin
    w_acc_n = r_acc + w_term;
    if (w_first)
      w_acc_n = w_term;
    else if (r_newdiag)
      w_acc_n = (r_acc <<< 1) + w_term;
  end

  // Term acceptance / walk / completion stage
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_pw        <= ONE;
      r_pd        <= ONE;
      r_sw        <= 1'b0;
      r_sd        <= 1'b0;
      r_iw        <= '0;
      r_id        <= '0;
      r_newdiag   <= 1'b0;
      r_busy      <= 1'b0;
      r_acc       <= '0;
      r_out_acc   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (in_valid) begin
        r_iw      <= w_iw_n;
        r_id      <= w_id_n;
        r_newdiag <= w_sh & ~w_wrap;
        r_acc     <= w_acc_n;
        if (w_first) begin
          r_pw <= w_pw;
          r_pd <= w_pd;
          r_sw <= w_sw;
          r_sd <= w_sd;
        end
        if (w_wrap) begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_out_acc   <= w_acc_n;
          r_out_valid <= 1'b1;
        end else begin
          r_state <= ST_ACC;
          r_busy  <= 1'b1;
        end
      end
    end
  end

`ifdef ZIGZAG_ACC_SH_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (clr)
      r_err <= 1'b0;
    else if (in_valid && !w_first && (in_sh != r_newdiag))
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  logic w_unused_sh;
  assign w_unused_sh = in_sh;
  assign err         = 1'b0;
`endif

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign busy      = r_busy;

endmodule

// File: tb/tb_zigzag_acc.sv
// Bench for zigzag_acc: directed multiplications checked against a diagonal-weight product model.
module tb_zigzag_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, sw, sd, in_valid, in_sh;
  logic [3:0]  pw, pd;
  logic [7:0]  in_pp;
  logic        out_valid, busy, err;
  logic signed [31:0] out_acc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  longint last_res = 0;
  int n_res = 0;
  logic [7:0] stim [0:15];

  zigzag_acc dut (
    .clk       (clk),
    .clr       (clr),
    .pw        (pw),
    .pd        (pd),
    .sw        (sw),
    .sd        (sd),
    .in_valid  (in_valid),
    .in_pp     (in_pp),
    .in_sh     (in_sh),
    .out_valid (out_valid),
    .out_acc   (out_acc),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int eff(input logic [3:0] p);
    return (p == 4'd0) ? 1 : int'(p);
  endfunction

  // Term k of the walk: diagonals in order, weight plane iw descending within each.
  function automatic void pos_of(input int p_w, input int p_d, input int k,
                                 output int iw, output int id, output int d);
    int c;
    c = 0; iw = 0; id = 0; d = 0;
    for (int dd = 0; dd < p_w + p_d - 1; dd++) begin
      for (int w = (dd < p_w - 1) ? dd : p_w - 1; w >= 0 && dd - w < p_d; w--) begin
        if (c == k) begin
          iw = w; id = dd - w; d = dd;
          return;
        end
        c++;
      end
    end
  endfunction

  // Product model: each term weighted by 2^(diagonals after its own).
  int m_pw, m_pd, m_k, mi_iw, mi_id, mi_d, mi_dp;
  bit m_sw, m_sd, m_busy, m_out_valid, m_err, m_exp_sh;
  longint m_sum, m_t;
  logic signed [31:0] m_out_acc = '0;

  always @(posedge clk) begin
    m_out_valid = 1'b0;
    if (clr) begin
      m_busy = 1'b0; m_out_acc = '0; m_err = 1'b0; m_k = 0;
    end else if (in_valid) begin
      if (!m_busy) begin
        m_pw = eff(pw); m_pd = eff(pd); m_sw = sw; m_sd = sd; m_k = 0; m_sum = 0;
      end
      pos_of(m_pw, m_pd, m_k, mi_iw, mi_id, mi_d);
      m_t = longint'(in_pp);
      if ((m_sw && mi_iw == 0 && m_pw > 1) ^ (m_sd && mi_id == 0 && m_pd > 1)) m_t = -m_t;
      m_sum = m_sum + m_t * (longint'(1) << (m_pw + m_pd - 2 - mi_d));
      if (m_k > 0) begin
        pos_of(m_pw, m_pd, m_k - 1, mi_iw, mi_id, mi_dp);
        m_exp_sh = (mi_d != mi_dp);
`ifdef ZIGZAG_ACC_SH_CHECK_EN
        if (in_sh != m_exp_sh) m_err = 1'b1;
`endif
      end
      m_k++;
      if (m_k == m_pw * m_pd) begin
        m_out_acc = m_sum[31:0]; m_out_valid = 1'b1; m_busy = 1'b0;
      end else begin
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, m_out_valid);
      chk("busy", busy, m_busy);
      chk("err", err, m_err);
      chk("out_acc", out_acc, m_out_acc);
      if (out_valid) begin
        last_res = out_acc;
        n_res++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic mul(input int p_w, input int p_d, input bit s_w, input bit s_d,
                     input int n, input int gapmax, input int flip, input bit ovl);
    int iw, id, d, dp;
    bit sh;
    pw = p_w[3:0]; pd = p_d[3:0]; sw = s_w; sd = s_d;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        repeat ($urandom_range(gapmax, 0)) begin
          in_valid = 1'b0; in_pp = 8'($urandom); in_sh = 1'($urandom);
          tick();
        end
      end
      pos_of(eff(p_w[3:0]), eff(p_d[3:0]), k, iw, id, d);
      sh = 1'b0;
      if (k > 0) begin
        pos_of(eff(p_w[3:0]), eff(p_d[3:0]), k - 1, iw, id, dp);
        sh = (d != dp);
      end
      in_valid = 1'b1; in_pp = stim[k]; in_sh = sh ^ (k == flip);
      if (k == 0 && ovl) chk("overlap_out_valid", out_valid, 1);
      tick();
      if (k == 0) begin
        pw = 4'($urandom); pd = 4'($urandom); sw = 1'($urandom); sd = 1'($urandom);
      end
    end
    in_valid = 1'b0;
  endtask

  int nres0;

  initial begin
    clr = 1'b1; pw = 4'd1; pd = 4'd1; sw = 1'b0; sd = 1'b0;
    in_valid = 1'b0; in_pp = 8'd0; in_sh = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    clr = 1'b0;
    tick();

    stim[0] = 8'd5;
    mul(1, 1, 0, 0, 1, 0, -1, 0);
    idle(2);
    chk("p11_result", last_res, 5);
    chk("p11_busy", busy, 0);
    chk("p11_count", n_res, 1);

    stim[0] = 8'd1; stim[1] = 8'd2; stim[2] = 8'd3; stim[3] = 8'd4;
    mul(2, 2, 0, 0, 4, 2, -1, 0);
    idle(2);
    chk("p22_unsigned", last_res, 18);

    mul(2, 2, 1, 1, 4, 1, -1, 0);
    idle(2);
    chk("p22_both_signed", last_res, -2);

    stim[0] = 8'd3; stim[1] = 8'd1;
    mul(2, 1, 1, 0, 2, 1, -1, 0);
    idle(2);
    chk("p21_signed", last_res, -5);
    mul(2, 1, 0, 0, 2, 1, -1, 0);
    idle(2);
    chk("p21_unsigned", last_res, 7);

    mul(0, 2, 1, 1, 2, 1, -1, 0);
    idle(2);
    chk("pw0_as_1", last_res, -5);

    for (int k = 0; k < 4; k++) stim[k] = 8'd1;
    nres0 = n_res;
    mul(2, 2, 0, 0, 3, 1, -1, 0);
    chk("abort_busy_before", busy, 1);
    clr = 1'b1; in_valid = 1'b1; in_pp = 8'd9;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_acc", out_acc, 0);
    tick();
    chk("abort_no_result", n_res, nres0);
    mul(2, 2, 0, 0, 4, 1, -1, 0);
    idle(2);
    chk("after_abort", last_res, 9);

    nres0 = n_res;
    for (int k = 0; k < 6; k++) stim[k] = 8'($urandom);
    mul(3, 2, 1, 0, 6, 2, -1, 0);
    for (int k = 0; k < 6; k++) stim[k] = 8'($urandom);
    mul(3, 2, 0, 1, 6, 2, -1, 1);
    idle(3);
    chk("b2b_count", n_res, nres0 + 2);

    mul(3, 2, 0, 0, 6, 1, -1, 0);
    idle(2);
    chk("sh_ok_err", err, 0);
    mul(3, 2, 0, 0, 6, 1, 3, 0);
    idle(2);
`ifdef ZIGZAG_ACC_SH_CHECK_EN
    chk("sh_flip_err", err, 1);
`else
    chk("sh_flip_err", err, 0);
`endif
    mul(3, 2, 0, 0, 6, 1, -1, 0);
    idle(2);
`ifdef ZIGZAG_ACC_SH_CHECK_EN
    chk("sh_sticky_err", err, 1);
`else
    chk("sh_sticky_err", err, 0);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("sh_clr_err", err, 0);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
